// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// Order-path UART receiver: 8 data bits, 1 stop bit, LSB first, idle-high line,
// no parity in the default build. Deserialises host order bytes from the FPGA
// input pin and hands each completed byte to the downstream order parser as a
// one-cycle valid pulse.
//
// Build option:
//   UART_RX_PARITY_EN - when defined, a PARITY state (even parity) is inserted
//                       between the last data bit and the stop bit, and
//                       parity_err reports mismatches. When undefined the frame
//                       is 10 bits and parity_err is tied low.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz   (default 100 MHz)
//   BAUD_RATE  line baud rate                 (default 115200)
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous, active-high reset
//   rx          in   asynchronous serial line from the pin
//   rx_data     out  [7:0] last good byte; holds its value between frames
//   rx_valid    out  one-cycle pulse: new byte in rx_data
//   rx_busy     out  high whenever the receiver is not idle
//   frame_err   out  one-cycle pulse: stop bit sampled low
//   parity_err  out  one-cycle pulse: parity mismatch (0 unless parity built in)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  // Bit timing is derived from the clock/baud pair and rounded to the nearest
  // whole cycle; it is deliberately not a parameter so it cannot drift from
  // the two rates it is computed from.
  localparam int CYCLES_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;

  // Terminal counts for the 16-bit cycle counter.
  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } state_t;
`endif

`ifdef UART_RX_PARITY_EN
  // Even-parity helper: returns 1 when the byte carries an odd number of ones,
  // i.e. the value the transmitter must have placed in the parity slot.
  function automatic logic parity_even(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Input synchroniser. Both stages reset high so a reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_s;

  // Two-flop synchroniser on the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_s = rx_sync_q;

  // ---------------------------------------------------------------------------
  // Receive state machine
  // ---------------------------------------------------------------------------
  state_t      state_q,      state_d;
  logic [15:0] cnt_q,        cnt_d;
  logic [2:0]  bit_idx_q,    bit_idx_d;
  logic [7:0]  shift_q,      shift_d;
  logic [7:0]  rx_data_q,    rx_data_d;
  logic        rx_valid_q,   rx_valid_d;
  logic        rx_busy_q,    rx_busy_d;
  logic        frame_err_q,  frame_err_d;
  logic        parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
  logic        mismatch_q,   mismatch_d;
`endif

  // State, counters, datapath and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_busy_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      mismatch_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_busy_q    <= rx_busy_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      mismatch_q   <= mismatch_d;
`endif
    end
  end

  // Next-state, counter and output decode. The counter free-runs inside a
  // state and is cleared on every transition, so each state measures its own
  // interval from the moment it was entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 16'd1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    mismatch_d   = mismatch_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (rx_s == 1'b0) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Re-check the start bit at its centre; a high line here was a glitch.
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = 16'd0;
          if (rx_s == 1'b0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end

      // One full bit time after the start-bit centre lands on each data-bit
      // centre. Shifting right leaves the first (LSB) bit in shift[0].
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = 16'd0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      // Record whether the received parity bit disagrees with even parity.
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = 16'd0;
          mismatch_d = parity_even(shift_q) ^ rx_s;
          state_d    = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif

      // Leave at the stop-bit centre rather than its end so that a start edge
      // immediately following the stop bit is not missed.
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = 16'd0;
          if (rx_s == 1'b1) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (mismatch_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_valid_d = 1'b1;
              rx_data_d  = shift_q;
            end
`else
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
`endif
          end else begin
            // A low stop bit takes precedence over any parity result.
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      // Park here while the line stays low so a held break produces one
      // frame error and is not re-read as a stream of start bits.
      ST_BREAK: begin
        cnt_d = 16'd0;
        if (rx_s == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = 16'd0;
        bit_idx_d = 3'd0;
      end
    endcase

    // Busy is registered from the next state so it tracks state_q exactly.
    if (state_d != ST_IDLE) begin
      rx_busy_d = 1'b1;
    end else begin
      rx_busy_d = 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_busy    = rx_busy_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle-high line. Default 115200 baud on a 100 MHz clock.
- Pairs with the order-path UART transmitter. Deserialises host order bytes from the FPGA input pin for the downstream order parser.
- Presents each received byte as a one-cycle valid pulse.
- Flags framing errors. With the optional feature compiled in, also flags parity errors.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line baud rate.
- Derived, not overridable: CYCLES_PER_BIT = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE = 868; HALF_BIT = CYCLES_PER_BIT/2 = 434.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- rx  input  1  asynchronous serial line from pin.
- rx_data  output  8  last good received byte; valid while rx_valid=1; otherwise holds its value.
- rx_valid  output  1  one-cycle pulse: new byte in rx_data.
- rx_busy  output  1  high in any state other than IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 unless UART_RX_PARITY_EN).

Behaviour:
- Input sync: 2-flop synchroniser on rx, both flops reset to 1. All decisions use the synchronised rx_s only.
- Reset values: rx_data=0x00, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0; state=IDLE; counters=0; shift reg=0.
- Reset mid-frame: aborts the frame immediately and returns to IDLE. No pulse is emitted.
- cnt: 16-bit cycle counter, cleared on every state transition. bit_idx: 3-bit.
- IDLE: when rx_s==0, go to START with cnt=0.
- START: at cnt==HALF_BIT-1, sample rx_s.
  - 0: go to DATA.
  - 1 (glitch/false start): go to IDLE; no pulse.
- DATA: at cnt==CYCLES_PER_BIT-1, shift rx_s into shift[7] (shift right), so the LSB is received first.
  - bit_idx 0..6: increment bit_idx.
  - bit_idx 7: clear bit_idx, go to STOP (or PARITY if the feature is enabled).
- STOP: at cnt==CYCLES_PER_BIT-1 (mid stop bit), sample rx_s.
  - rx_s=1, no parity error: rx_data<=shift, rx_valid=1 for one cycle, go to IDLE.
  - rx_s=1, parity error: parity_err=1 for one cycle, rx_data unchanged, go to IDLE.
  - rx_s=0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A line held low (break) yields exactly one frame_err and no further starts.
- Back-to-back: STOP returns to IDLE at mid stop bit, so a start edge immediately after the stop bit is captured. No idle gap is required.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CYCLES_PER_BIT cycles (±1) after the first clk edge at which pin rx reads 0. Nominal is 8248 cycles.
- Pulse exclusivity: rx_valid, frame_err and parity_err are mutually exclusive and never high for more than one cycle.
- Sampling: single sample per bit at the bit centre; no majority vote.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - State PARITY is inserted between DATA and STOP.
  - At cnt==CYCLES_PER_BIT-1 it samples the parity bit and records mismatch = (^shift) ^ rx_s. Even parity: mismatch when nonzero.
  - STOP then reports parity_err instead of rx_valid on mismatch. A low stop bit reports frame_err instead of parity_err.
  - Latency grows by CYCLES_PER_BIT.
- Undefined: no PARITY state; parity_err is tied to 0; the frame is 10 bits.

Test Plan:
- Send 0x55 at 868 cycles/bit -> one rx_valid, rx_data=0x55, rx_valid asserted 8248±1 cycles after the start edge; frame_err=0.
- Send 0x00, 0xFF, 0xA5 back-to-back with no idle gap -> three rx_valid pulses, data 0x00, 0xFF, 0xA5 in order; no errors.
- Drive rx low for 200 cycles then high -> no pulses; rx_busy returns low after ~436 cycles; a following 0x3C is received correctly.
- Send 0xA5 with stop bit low, then line high -> frame_err pulse, rx_data stays 0x3C (previous), state back to IDLE.
- Hold rx low for 20 bit times -> exactly one frame_err, rx_busy high until rx returns high, then 0x81 is received correctly.
- Assert rst for 1 cycle at bit 4 of 0x5A, then send 0xC3 -> no pulse for the aborted frame; rx_valid with 0xC3. With UART_RX_PARITY_EN, 0x07 with parity bit 0 -> parity_err and no rx_valid.
